// File: rtl/mmcm_seq_pkg.sv
// Shared types and defaults for the clocking-primitive reset sequencer.
package mmcm_seq_pkg;

    typedef enum logic [2:0] {
        PULSE,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL,
        PDOWN
    } state_t;

    localparam int unsigned DEF_RST_PULSE_CYCLES     = 8;
    localparam int unsigned DEF_LOCK_TIMEOUT_CYCLES  = 1000;
    localparam int unsigned DEF_LOCK_STABLE_CYCLES   = 16;
    localparam int unsigned DEF_RELEASE_DELAY_CYCLES = 16;
    localparam int unsigned DEF_MAX_RETRIES          = 3;
    localparam int unsigned DEF_CNT_W                = 16;
    localparam int unsigned LOST_CNT_W               = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level, cleared by a synchronous reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mmcm_reset_sequencer.sv
// Drives the clocking primitive's rst/pwrdwn pins, waits for a stable lock with
// timeout and retries, and releases the downstream system reset once locked.
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int unsigned RST_PULSE_CYCLES     = DEF_RST_PULSE_CYCLES,
    parameter int unsigned LOCK_TIMEOUT_CYCLES  = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int unsigned LOCK_STABLE_CYCLES   = DEF_LOCK_STABLE_CYCLES,
    parameter int unsigned RELEASE_DELAY_CYCLES = DEF_RELEASE_DELAY_CYCLES,
    parameter int unsigned MAX_RETRIES          = DEF_MAX_RETRIES,
    parameter int unsigned CNT_W                = DEF_CNT_W
) (
    input  logic                               clkin1,
    input  logic                               rst,
    input  logic                               locked,
    input  logic                               pwrdwn_req,
    input  logic                               relock_req,
    output logic                               mmcm_rst,
    output logic                               mmcm_pwrdwn,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fail,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOST_CNT_W-1:0]              lost_cnt
);

    localparam int unsigned RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   RELEASE_LAST = CNT_W'(RELEASE_DELAY_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

    state_t                  state;
    state_t                  state_nxt;
    logic [CNT_W-1:0]        cnt;
    logic [RETRY_W-1:0]      retry_nxt;
    logic [LOST_CNT_W-1:0]   lost_nxt;
    logic                    locked_s;
    logic                    mmcm_rst_nxt;
    logic                    mmcm_pwrdwn_nxt;
    logic                    sys_rst_nxt;
    logic                    ready_nxt;
    logic                    fail_nxt;

    sync_2ff u_lock_sync (
        .clk (clkin1),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // State, shared counter and registered Moore outputs.
    always_ff @(posedge clkin1) begin
        if (rst) begin
            state       <= PULSE;
            cnt         <= '0;
            retry_cnt   <= '0;
            lost_cnt    <= '0;
            mmcm_rst    <= 1'b1;
            mmcm_pwrdwn <= 1'b0;
            sys_rst     <= 1'b1;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_nxt;
            retry_cnt   <= retry_nxt;
            lost_cnt    <= lost_nxt;
            mmcm_rst    <= mmcm_rst_nxt;
            mmcm_pwrdwn <= mmcm_pwrdwn_nxt;
            sys_rst     <= sys_rst_nxt;
            ready       <= ready_nxt;
            fail        <= fail_nxt;
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt != '1) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Next state; outputs are decoded from the next state so they line up with it.
    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        lost_nxt  = lost_cnt;

        case (state)
            PULSE: begin
                if (cnt == PULSE_LAST) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    state_nxt = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = FAIL;
                    end else begin
                        retry_nxt = retry_cnt + RETRY_W'(1);
                        state_nxt = PULSE;
                    end
                end
            end
            STABLE: begin
                if (!locked_s) begin
                    state_nxt = WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RELEASE;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_nxt = PULSE;
                end else if (cnt == RELEASE_LAST) begin
                    retry_nxt = '0;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    if (lost_cnt != '1) lost_nxt = lost_cnt + LOST_CNT_W'(1);
                    state_nxt = PULSE;
                end else if (relock_req) begin
                    state_nxt = PULSE;
                end
            end
            FAIL: begin
                if (relock_req) begin
                    retry_nxt = '0;
                    state_nxt = PULSE;
                end
            end
            PDOWN: begin
                retry_nxt = '0;
                state_nxt = PULSE;
            end
            default: state_nxt = PULSE;
        endcase

        // Power-down overrides everything except rst and discards this cycle's updates.
        if (pwrdwn_req) begin
            state_nxt = PDOWN;
            retry_nxt = retry_cnt;
            lost_nxt  = lost_cnt;
        end

        mmcm_rst_nxt    = (state_nxt == PULSE) || (state_nxt == PDOWN);
        mmcm_pwrdwn_nxt = (state_nxt == PDOWN);
        sys_rst_nxt     = (state_nxt != RUN);
        ready_nxt       = (state_nxt == RUN);
        fail_nxt        = (state_nxt == FAIL);
    end

endmodule
